// File: rtl/stack_bank.sv
// Bank of NSTK independent LIFO stacks sharing one storage array addressed {SEL, index}.
// Define STACK_BOUNDS_CHECK_EN to guard full/empty stacks and raise sticky OVF/UFL flags.
module stack_bank #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 64,
    parameter  int NSTK   = 2,
    localparam int PW     = $clog2(DEPTH) + 1,
    localparam int SW     = $clog2(NSTK)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [SW-1:0]      SEL,
    input  logic               PUSH,
    input  logic               POP,
    input  logic [DATA_W-1:0]  WDATA,
    input  logic               CLR_ERR,
    output logic [DATA_W-1:0]  RDATA,
    output logic               RVALID,
    output logic [NSTK*PW-1:0] SP_ALL,
    output logic [NSTK-1:0]    FULL,
    output logic [NSTK-1:0]    EMPTY,
    output logic [NSTK-1:0]    OVF,
    output logic [NSTK-1:0]    UFL
);

    localparam logic [PW-1:0] SP_ONE    = PW'(1);
    localparam logic [PW-2:0] IDX_ONE   = (PW-1)'(1);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);

    logic [DATA_W-1:0] mem [NSTK*DEPTH];
    logic [PW-1:0]     sp  [NSTK];

    logic [PW-1:0] cur;
    logic [PW-2:0] top_idx;
    logic [PW-2:0] wr_idx;
    logic          is_empty;
    logic          do_write;
    logic          do_read;
    logic          sp_inc;
    logic          sp_dec;

    assign cur      = sp[SEL];
    assign top_idx  = cur[PW-2:0] - IDX_ONE;
    assign is_empty = (cur == '0);

`ifdef STACK_BOUNDS_CHECK_EN
    logic            is_full;
    logic            set_ovf;
    logic            set_ufl;
    logic [NSTK-1:0] sel_mask;

    assign is_full  = (cur == DEPTH_CNT);
    assign sel_mask = NSTK'(1) << SEL;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        sp_inc   = 1'b0;
        sp_dec   = 1'b0;
        wr_idx   = cur[PW-2:0];
`ifdef STACK_BOUNDS_CHECK_EN
        set_ovf  = 1'b0;
        set_ufl  = 1'b0;
`endif
        if (PUSH && POP) begin
            if (!is_empty) begin
                do_read  = 1'b1;
                do_write = 1'b1;
                wr_idx   = top_idx;
            end else begin
`ifdef STACK_BOUNDS_CHECK_EN
                // Nothing to pop: the push goes ahead on its own.
                set_ufl  = 1'b1;
                do_write = 1'b1;
                sp_inc   = 1'b1;
`else
                do_read  = 1'b1;
                do_write = 1'b1;
                wr_idx   = top_idx;
`endif
            end
        end else if (PUSH) begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (is_full) begin
                set_ovf = 1'b1;
            end else begin
                do_write = 1'b1;
                sp_inc   = 1'b1;
            end
`else
            do_write = 1'b1;
            sp_inc   = 1'b1;
`endif
        end else if (POP) begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (is_empty) begin
                set_ufl = 1'b1;
            end else begin
                do_read = 1'b1;
                sp_dec  = 1'b1;
            end
`else
            do_read = 1'b1;
            sp_dec  = 1'b1;
`endif
        end
    end

    // NOTE: storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[{SEL, wr_idx}] <= WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NSTK; k++) begin
                sp[k] <= '0;
            end
            RVALID <= 1'b0;
            RDATA  <= '0;
        end else begin
            RVALID <= do_read;
            if (do_read) begin
                RDATA <= mem[{SEL, top_idx}];
            end
            if (sp_inc) begin
                sp[SEL] <= cur + SP_ONE;
            end else if (sp_dec) begin
                sp[SEL] <= cur - SP_ONE;
            end
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    // A same-cycle error event wins over CLR_ERR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVF <= '0;
            UFL <= '0;
        end else begin
            OVF <= (CLR_ERR ? '0 : OVF) | (set_ovf ? sel_mask : '0);
            UFL <= (CLR_ERR ? '0 : UFL) | (set_ufl ? sel_mask : '0);
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = CLR_ERR;
    assign OVF            = '0;
    assign UFL            = '0;
`endif

    for (genvar k = 0; k < NSTK; k++) begin : g_status
        assign SP_ALL[k*PW +: PW] = sp[k];
        assign FULL[k]            = (sp[k] == DEPTH_CNT);
        assign EMPTY[k]           = (sp[k] == '0);
    end

endmodule

// File: doc/stack_bank.md
STACK_BANK -- requirements
Module: stack_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, stack entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, entries per stack; power of two, at least 4.
REQ-003 SHALL have parameter NSTK, default 2, number of independent stacks (stack 0 = main, stack 1 = return); at least 2. Derived: PW = log2(DEPTH)+1, SW = log2(NSTK).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port SEL, input, SW bits: stack addressed by this cycle's operation.
REQ-007 SHALL have port PUSH, input, 1 bit: push WDATA onto stack SEL.
REQ-008 SHALL have port POP, input, 1 bit: pop the top of stack SEL.
REQ-009 SHALL have port WDATA, input, DATA_W bits: push data.
REQ-010 SHALL have port CLR_ERR, input, 1 bit: clear all sticky error flags.
REQ-011 SHALL have port RDATA, output, DATA_W bits: popped data.
REQ-012 SHALL have port RVALID, output, 1 bit: RDATA valid this cycle.
REQ-013 SHALL have port SP_ALL, output, NSTK*PW bits: entry count of every stack; stack k at bits [k*PW +: PW].
REQ-014 SHALL have ports FULL and EMPTY, output, NSTK bits each: per-stack count==DEPTH and count==0.
REQ-015 SHALL have ports OVF and UFL, output, NSTK bits each: sticky per-stack overflow and underflow flags.

Function
REQ-016 SHALL keep all stacks in one storage array of NSTK*DEPTH entries, addressed {SEL, index}; storage contents are not reset.
REQ-017 SHALL, on PUSH alone, write WDATA to entry SP[SEL] of stack SEL and increment SP[SEL] by 1 at the same edge.
REQ-018 SHALL, on POP alone, decrement SP[SEL] by 1, register entry SP[SEL]-1 onto RDATA and assert RVALID for exactly the following cycle; latency is 1 cycle.
REQ-019 SHALL, on PUSH and POP together with SP[SEL]>0, return the old top on RDATA/RVALID next cycle, overwrite the top entry with WDATA, and leave SP[SEL] unchanged.
REQ-020 SHALL leave stacks other than SEL unchanged in every cycle.
REQ-021 SHALL hold RVALID low and RDATA at its last value in every cycle not following an accepted pop.
REQ-022 SHALL, when SP_ALL, FULL and EMPTY are read in the cycle after an operation, reflect that operation.
REQ-023 SHALL, on CLR_ERR, clear OVF and UFL; an error event in the same cycle takes priority and sets its bit.

Reset
REQ-024 SHALL, while RST_N is low and independent of CLK, force every SP to 0, EMPTY to all ones, FULL, OVF and UFL to all zeros, RVALID to 0, and RDATA to 0.
REQ-025 SHALL, when reset asserts during a pop, drop that pop's pending RVALID.
REQ-026 SHALL accept the first operation on the first rising edge after RST_N deasserts.

Configuration
REQ-027 SHALL, when STACK_BOUNDS_CHECK_EN is defined, behave as follows:
- PUSH alone on a full stack: ignored; OVF[SEL] set.
- POP on an empty stack: suppressed; no RVALID; UFL[SEL] set.
- PUSH with POP on an empty stack: the push proceeds alone and UFL[SEL] is set.
REQ-028 SHALL, when STACK_BOUNDS_CHECK_EN is not defined:
- tie OVF and UFL to 0;
- wrap the index modulo DEPTH while counting SP modulo 2*DEPTH;
- perform full pushes and empty pops unchecked.

Verification
REQ-029 SHALL cover push-pop ordering: after reset, push 0x1111, 0x2222, 0x3333 to stack 0, then pop three times -> RDATA 0x3333, 0x2222, 0x1111, each with RVALID one cycle after its POP; SP[0] ends at 0.
REQ-030 SHALL cover stack isolation: push 0xAAAA to stack 0 and 0xBBBB to stack 1, then pop stack 1 -> RDATA 0xBBBB, SP[0]=1, SP[1]=0.
REQ-031 SHALL cover simultaneous push and pop: with stack 0 holding 0x0005, assert PUSH+POP with WDATA=0x0009 -> RDATA 0x0005, SP unchanged; a later pop -> 0x0009.
REQ-032 SHALL cover bounds checking with STACK_BOUNDS_CHECK_EN defined:
- 65 pushes to stack 1 -> FULL[1]=1, OVF[1]=1, SP[1]=64;
- a pop on empty stack 0 -> UFL[0]=1, no RVALID;
- CLR_ERR -> OVF and UFL cleared.
REQ-033 SHALL cover reset mid-operation: assert RST_N low between a POP edge and the following cycle -> RVALID stays 0, every SP reads 0, and EMPTY reads all ones.
